// File: rtl/uncache_ctrl.sv
// Uncached-access controller between the LSU data-SRAM port and the AXI bridge.
// Uncached stores are posted into a circular write buffer so the pipeline keeps
// going; uncached loads stall until the buffer has drained and the read returns.
//
// Bus handshake (valid/ready style):
//   bus_req is the valid. It and bus_we/addr/wdata/wsel are registered and are
//   held stable while bus_req=1 and bus_ack=0. The transfer completes in the
//   cycle where bus_req & bus_ack. bus_req is 0 in the next cycle, so there is
//   always at least a one-cycle gap. bus_ack is ignored while bus_req=0.
module uncache_ctrl #(
    parameter int ADDR_W     = 64,
    parameter int DATA_W     = 64,
    parameter int WBUF_DEPTH = 4
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                req_e,
    input  logic                req_we,
    input  logic [ADDR_W-1:0]   req_addr,
    input  logic [DATA_W-1:0]   req_wdata,
    input  logic [DATA_W/8-1:0] req_sel,
    input  logic                uncache,
    output logic                stallreq,
    output logic [DATA_W-1:0]   rdata,
    output logic                rdata_valid,
    output logic                wbuf_empty,
    output logic                bus_req,
    output logic                bus_we,
    output logic [ADDR_W-1:0]   bus_addr,
    output logic [DATA_W-1:0]   bus_wdata,
    output logic [DATA_W/8-1:0] bus_wsel,
    input  logic                bus_ack,
    input  logic [DATA_W-1:0]   bus_rdata,
    output logic [1:0]          dbg_state_o
);
    localparam int SEL_W = DATA_W / 8;
    localparam int IDX_W = $clog2(WBUF_DEPTH);
    localparam int PTR_W = IDX_W + 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WR   = 2'd1,
        RD   = 2'd2,
        DONE = 2'd3
    } state_e;

    state_e state_q, state_d;

    // Write buffer storage; validity is tracked by the pointers alone.
    logic [ADDR_W-1:0] wb_addr_q  [WBUF_DEPTH];
    logic [DATA_W-1:0] wb_wdata_q [WBUF_DEPTH];
    logic [SEL_W-1:0]  wb_sel_q   [WBUF_DEPTH];
    logic [PTR_W-1:0]  wr_ptr_q, rd_ptr_q;
    logic [IDX_W-1:0]  wr_idx, rd_idx;

    logic              bus_req_q, bus_req_d;
    logic              bus_we_q, bus_we_d;
    logic [ADDR_W-1:0] bus_addr_q, bus_addr_d;
    logic [DATA_W-1:0] bus_wdata_q, bus_wdata_d;
    logic [SEL_W-1:0]  bus_wsel_q, bus_wsel_d;
    logic              ld_pend_q, ld_pend_d;
    logic [ADDR_W-1:0] ld_addr_q, ld_addr_d;
    logic [DATA_W-1:0] rdata_q, rdata_d;

    logic empty, full, push, pop, ack_v, ld_seen, ld_pend;

    assign wr_idx = wr_ptr_q[IDX_W-1:0];
    assign rd_idx = rd_ptr_q[IDX_W-1:0];
    assign empty  = (wr_ptr_q == rd_ptr_q);
    assign full   = (wr_ptr_q[PTR_W-1] != rd_ptr_q[PTR_W-1]) && (wr_idx == rd_idx);

    // full comes from registered pointers, so a same-cycle pop never frees a slot
    // for that cycle's push.
    assign push    = req_e & req_we & uncache & ~full;
    assign ack_v   = bus_req_q & bus_ack;
    assign pop     = (state_q == WR) & ack_v;
    // A load is seen on every cycle it is presented except the completion cycle.
    assign ld_seen = req_e & ~req_we & uncache & (state_q != DONE);
    assign ld_pend = ld_pend_q | ld_seen;

    assign stallreq    = req_e & uncache & (req_we ? full : (state_q != DONE));
    assign rdata       = rdata_q;
    assign rdata_valid = (state_q == DONE);
    assign wbuf_empty  = empty & (state_q != WR);
    assign bus_req     = bus_req_q;
    assign bus_we      = bus_we_q;
    assign bus_addr    = bus_addr_q;
    assign bus_wdata   = bus_wdata_q;
    assign bus_wsel    = bus_wsel_q;
    assign dbg_state_o = state_q;

    // Write buffer data: store the accepted request at the tail.
    always_ff @(posedge clk) begin
        if (push) begin
            wb_addr_q[wr_idx]  <= req_addr;
            wb_wdata_q[wr_idx] <= req_wdata;
            wb_sel_q[wr_idx]   <= req_sel;
        end
    end

    // Next state, bus register loads, load latch and read-data capture.
    always_comb begin
        state_d     = state_q;
        bus_req_d   = bus_req_q;
        bus_we_d    = bus_we_q;
        bus_addr_d  = bus_addr_q;
        bus_wdata_d = bus_wdata_q;
        bus_wsel_d  = bus_wsel_q;
        ld_pend_d   = ld_pend_q;
        ld_addr_d   = ld_addr_q;
        rdata_d     = rdata_q;

        if (ld_seen && !ld_pend_q) begin
            ld_pend_d = 1'b1;
            ld_addr_d = req_addr;
        end

        unique case (state_q)
            IDLE: begin
                // Writes first: a load may only go out once every older store has.
                // An empty buffer with a push this cycle forwards the request
                // straight onto the bus so the write starts one cycle later.
                if (!empty || push) begin
                    state_d     = WR;
                    bus_req_d   = 1'b1;
                    bus_we_d    = 1'b1;
                    bus_addr_d  = empty ? req_addr  : wb_addr_q[rd_idx];
                    bus_wdata_d = empty ? req_wdata : wb_wdata_q[rd_idx];
                    bus_wsel_d  = empty ? req_sel   : wb_sel_q[rd_idx];
                end else if (ld_pend) begin
                    state_d     = RD;
                    bus_req_d   = 1'b1;
                    bus_we_d    = 1'b0;
                    bus_addr_d  = ld_pend_q ? ld_addr_q : req_addr;
                    bus_wdata_d = '0;
                    bus_wsel_d  = '0;
                end
            end
            WR: begin
                if (ack_v) begin
                    state_d   = IDLE;
                    bus_req_d = 1'b0;
                end
            end
            RD: begin
                if (ack_v) begin
                    state_d   = DONE;
                    bus_req_d = 1'b0;
                    rdata_d   = bus_rdata;
                end
            end
            DONE: begin
                // The held load is released this cycle and must not be reissued.
                state_d   = IDLE;
                ld_pend_d = 1'b0;
            end
            default: state_d = IDLE;
        endcase
    end

    // State, pointers and bus registers; reset abandons any transfer and buffered stores.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            bus_req_q   <= 1'b0;
            bus_we_q    <= 1'b0;
            bus_addr_q  <= '0;
            bus_wdata_q <= '0;
            bus_wsel_q  <= '0;
            ld_pend_q   <= 1'b0;
            ld_addr_q   <= '0;
            rdata_q     <= '0;
        end else begin
            state_q     <= state_d;
            if (push) wr_ptr_q <= wr_ptr_q + PTR_W'(1);
            if (pop)  rd_ptr_q <= rd_ptr_q + PTR_W'(1);
            bus_req_q   <= bus_req_d;
            bus_we_q    <= bus_we_d;
            bus_addr_q  <= bus_addr_d;
            bus_wdata_q <= bus_wdata_d;
            bus_wsel_q  <= bus_wsel_d;
            ld_pend_q   <= ld_pend_d;
            ld_addr_q   <= ld_addr_d;
            rdata_q     <= rdata_d;
        end
    end

endmodule
